// File: rtl/fsk_frame_receiver.sv
// fsk_frame_receiver: hunts a sync byte in the demodulated bit stream, then
// collects a 16-bit {data, crc} codeword MSB first, checks it with a
// bit-serial CRC-8 and presents the data byte with valid/error flags.
module fsk_frame_receiver #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter logic [7:0] POLY      = 8'h07,
  parameter int         TIMEOUT   = 64
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       crc_err,
  output logic       frame_abort,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  // One bit-serial CRC-8 step; the x^8 term is implicit in the feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    sync_q, sync_d;
  logic [15:0]   shift_q, shift_d;
  logic [7:0]    crc_q, crc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          crc_err_q, crc_err_d;
  logic          frame_abort_q, frame_abort_d;
  logic          busy_q, busy_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [7:0]    sync_shift_s;
  logic [15:0]   shift_next_s;
  logic [7:0]    crc_next_s;

  // Next-state and output computation for the HUNT/RECV framer.
  always_comb begin
    state_d       = state_q;
    sync_d        = sync_q;
    shift_d       = shift_q;
    crc_d         = crc_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    crc_err_d     = crc_err_q;
    frame_abort_d = 1'b0;
    err_cnt_d     = err_cnt_q;

    sync_shift_s  = {sync_q[6:0], bit_in};
    shift_next_s  = {shift_q[14:0], bit_in};
    crc_next_s    = crc8_step(crc_q, bit_in);

    case (state_q)
      ST_HUNT: begin
        if (bit_valid) begin
          sync_d = sync_shift_s;
          if (sync_shift_s == SYNC_WORD) begin
            // Clear the hunter so stale bits cannot re-trigger after this frame.
            state_d = ST_RECV;
            sync_d  = 8'h00;
            shift_d = 16'h0000;
            crc_d   = 8'h00;
            cnt_d   = 4'd0;
            tmo_d   = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_RECV: begin
        if (bit_valid) begin
          shift_d = shift_next_s;
          crc_d   = crc_next_s;
          cnt_d   = cnt_q + 4'd1;
          tmo_d   = '0;
          if (cnt_q == 4'd15) begin
            state_d      = ST_HUNT;
            data_valid_d = 1'b1;
            data_out_d   = shift_next_s[15:8];
            crc_err_d    = (crc_next_s != 8'h00);
            if ((crc_next_s != 8'h00) && (err_cnt_q != 8'hFF)) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else begin
            state_d = ST_RECV;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Transmitter went quiet mid-frame: drop it, keep last good outputs.
          state_d       = ST_HUNT;
          frame_abort_d = 1'b1;
          tmo_d         = '0;
        end else begin
          tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    busy_d = (state_d == ST_RECV);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      sync_q        <= 8'h00;
      shift_q       <= 16'h0000;
      crc_q         <= 8'h00;
      cnt_q         <= 4'd0;
      tmo_q         <= '0;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      crc_err_q     <= 1'b0;
      frame_abort_q <= 1'b0;
      busy_q        <= 1'b0;
      err_cnt_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      shift_q       <= shift_d;
      crc_q         <= crc_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      crc_err_q     <= crc_err_d;
      frame_abort_q <= frame_abort_d;
      busy_q        <= busy_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign crc_err     = crc_err_q;
  assign frame_abort = frame_abort_q;
  assign busy        = busy_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_fsk_frame_receiver.sv
// Directed bench for fsk_frame_receiver: sync hunting, CRC pass/fail,
// inter-bit timeout, mid-frame reset and err_cnt saturation.
module tb_fsk_frame_receiver;

  localparam int TIMEOUT = 64;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       crc_err;
  logic       frame_abort;
  logic       busy;
  logic [7:0] err_cnt;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int dv_cnt   = 0;
  int ab_cnt   = 0;
  int busy_cnt = 0;

  fsk_frame_receiver #(
    .SYNC_WORD(8'hA5),
    .POLY     (8'h07),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .crc_err    (crc_err),
    .frame_abort(frame_abort),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  // Free-running clock.
  always #5 sys_clk = ~sys_clk;

  // Pulse/level counters sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (data_valid)  dv_cnt   <= dv_cnt + 1;
    if (frame_abort) ab_cnt   <= ab_cnt + 1;
    if (busy)        busy_cnt <= busy_cnt + 1;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one bit, then idles so that the bit period is 'gap' cycles.
  // Entered and left at posedge+1.
  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge sys_clk); #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    for (int k = 1; k < gap; k++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic send_sync(input int gap);
    logic [7:0] sw;
    sw = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(sw[i], gap);
  endtask

  // Sync + codeword; the last bit is followed directly by the result check.
  task automatic send_frame(input string tag, input logic [15:0] cw, input int gap,
                            input logic [7:0] exp_data, input logic exp_err,
                            input logic [7:0] exp_cnt);
    send_sync(gap);
    for (int i = 15; i >= 1; i--) send_bit(cw[i], gap);
    send_bit(cw[0], 1);
    chk({tag, "_dv"},   {31'd0, data_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, data_out},   {24'd0, exp_data});
    chk({tag, "_err"},  {31'd0, crc_err},    {31'd0, exp_err});
    chk({tag, "_cnt"},  {24'd0, err_cnt},    {24'd0, exp_cnt});
    @(posedge sys_clk); #1;
    chk({tag, "_dv_low"}, {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    int dv0, ab0, bz0;
    logic [15:0] good;
    logic [15:0] bad;
    logic [15:0] noise;
    good  = 16'h3197;
    bad   = 16'h3196;
    noise = 16'h0F0F;

    reset     = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_data",  {24'd0, data_out},    32'd0);
    chk("rst_dv",    {31'd0, data_valid},  32'd0);
    chk("rst_err",   {31'd0, crc_err},     32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    chk("rst_busy",  {31'd0, busy},        32'd0);
    chk("rst_cnt",   {24'd0, err_cnt},     32'd0);
    reset = 1'b0;
    @(posedge sys_clk); #1;

    // Good frame, then bad CRC, then all-zero codeword.
    send_frame("good1", good, 4, 8'h31, 1'b0, 8'd0);
    send_frame("bad1", bad, 4, 8'h31, 1'b1, 8'd1);
    send_frame("zero", 16'h0000, 4, 8'h00, 1'b0, 8'd1);

    // Leading noise 101 before sync.
    send_bit(1'b1, 3);
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    send_frame("noisy", 16'hFFF3, 3, 8'hFF, 1'b0, 8'd1);

    // Noise without any A5 window keeps the framer hunting.
    bz0 = busy_cnt;
    for (int i = 15; i >= 0; i--) send_bit(noise[i], 2);
    repeat (2) @(posedge sys_clk);
    #1;
    chk("noise_busy", busy_cnt - bz0, 32'd0);

    // Timeout: sync plus 5 bits, then silence.
    send_sync(4);
    for (int i = 15; i >= 12; i--) send_bit(good[i], 4);
    send_bit(good[11], 1);
    dv0 = dv_cnt;
    ab0 = ab_cnt;
    chk("tmo_busy_on", {31'd0, busy}, 32'd1);
    repeat (TIMEOUT - 4) @(posedge sys_clk);
    #1;
    chk("tmo_early", ab_cnt - ab0, 32'd0);
    chk("tmo_busy_hold", {31'd0, busy}, 32'd1);
    repeat (8) @(posedge sys_clk);
    #1;
    chk("tmo_abort", ab_cnt - ab0, 32'd1);
    chk("tmo_busy_off", {31'd0, busy}, 32'd0);
    chk("tmo_no_dv", dv_cnt - dv0, 32'd0);
    chk("tmo_data", {24'd0, data_out}, 32'h0000_00FF);
    chk("tmo_cnt", {24'd0, err_cnt}, 32'd1);
    send_frame("after_tmo", good, 4, 8'h31, 1'b0, 8'd1);

    // Reset in the middle of a frame.
    send_sync(2);
    for (int i = 15; i >= 6; i--) send_bit(good[i], 2);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    chk("mrst_data",  {24'd0, data_out},    32'd0);
    chk("mrst_dv",    {31'd0, data_valid},  32'd0);
    chk("mrst_err",   {31'd0, crc_err},     32'd0);
    chk("mrst_abort", {31'd0, frame_abort}, 32'd0);
    chk("mrst_busy",  {31'd0, busy},        32'd0);
    chk("mrst_cnt",   {24'd0, err_cnt},     32'd0);
    dv0 = dv_cnt;
    bz0 = busy_cnt;
    for (int i = 5; i >= 0; i--) send_bit(good[i], 2);
    repeat (4) @(posedge sys_clk);
    #1;
    chk("mrst_no_dv", dv_cnt - dv0, 32'd0);
    chk("mrst_no_busy", busy_cnt - bz0, 32'd0);

    // 256 back-to-back bad frames at one bit per cycle.
    dv0 = dv_cnt;
    for (int f = 0; f < 255; f++) begin
      send_sync(1);
      for (int i = 15; i >= 0; i--) send_bit(bad[i], 1);
    end
    send_frame("sat", bad, 1, 8'h31, 1'b1, 8'hFF);
    chk("sat_frames", dv_cnt - dv0, 32'd256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
